// File: rtl/imem_fetch_unit.sv
// Instruction-fetch front end: drives the SRAM read port and turns its one-cycle read latency into a valid/ready instruction stream.
// Optional misaligned-redirect fault handling is enabled by defining IMEM_MISALIGN_FAULT_EN.
module imem_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [31:0]           inst_pc,
  output logic                  fetch_fault,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

  state_t                state;
  logic [31:0]           pc;
  logic [31:0]           pend_pc;
  logic                  pending;
  logic                  fault_q;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           count;
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [31:0]           mem_pc   [FIFO_DEPTH];

  logic [31:0]           tgt_pc;
  logic                  misalign;
  logic [31:0]           req_pc;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [PW+1:0]         occ;
  logic [PW:0]           cnt_left;
  logic [PW:0]           cnt_next;
  logic [PW-1:0]         rd_next;
  logic [PW-1:0]         wr_next;
  logic [DATA_WIDTH-1:0] head_data;
  logic [31:0]           head_pc;

`ifdef IMEM_MISALIGN_FAULT_EN
  assign tgt_pc   = redirect_pc;
  assign misalign = |redirect_pc[1:0];
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign tgt_pc   = {redirect_pc[31:2], 2'b00};
  assign misalign = 1'b0;
`endif

  assign fetch_fault = fault_q;
  assign sram_csb    = ~issue;
  assign sram_addr   = req_pc[ADDR_WIDTH+1:2];

  always_comb begin
    pop    = inst_valid & inst_ready & ~redirect_valid;
    push   = pending & ~redirect_valid;
    req_pc = redirect_valid ? tgt_pc : pc;
    // Outstanding = queued + in flight; the slot freed by this cycle's pop is reusable.
    occ    = (PW+2)'(count) + (PW+2)'(pending) - (PW+2)'(pop);
    issue  = 1'b0;
    case (state)
      S_RUN:   issue = redirect_valid ? ~misalign : (occ < DEPTH_W);
      S_FAULT: issue = redirect_valid & ~misalign;
      default: issue = 1'b0;
    endcase

    cnt_left = count - (PW+1)'(pop);
    cnt_next = redirect_valid ? '0 : cnt_left + (PW+1)'(push);
    rd_next  = redirect_valid ? '0 : rd_ptr + PW'(pop);
    wr_next  = redirect_valid ? '0 : wr_ptr + PW'(push);

    // Head after this edge comes from the incoming response when nothing older remains.
    if (cnt_left == '0) begin
      head_data = sram_dout;
      head_pc   = pend_pc;
    end else begin
      head_data = mem_data[rd_next];
      head_pc   = mem_pc[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= sram_dout;
      mem_pc[wr_ptr]   <= pend_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      pending    <= 1'b0;
      fault_q    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else begin
      if (issue) begin
        pc <= req_pc + 32'd4;
      end else if (redirect_valid) begin
        pc <= tgt_pc;
      end
      pending <= issue;
      if (issue) begin
        pend_pc <= req_pc;
      end

      count      <= cnt_next;
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      inst_valid <= (cnt_next != '0);
      if (cnt_next != '0) begin
        inst_data <= head_data;
        inst_pc   <= head_pc;
      end

      if (redirect_valid && misalign) begin
        state   <= S_FAULT;
        fault_q <= 1'b1;
        inst_pc <= redirect_pc;
      end else begin
        case (state)
          S_BOOT:  state <= S_RUN;
          S_RUN:   state <= S_RUN;
          S_FAULT: begin
            if (redirect_valid) begin
              state   <= S_RUN;
              fault_q <= 1'b0;
            end
          end
          default: state <= S_BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: stream-order model plus directed literal checks.
// Exercises the fault path as well when IMEM_MISALIGN_FAULT_EN is defined.
module tb_imem_fetch_unit;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          inst_ready = 1'b1;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [31:0]   inst_pc;
  logic          fetch_fault;
  logic          sram_csb;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout = '0;

  logic [31:0]   sram_mem [512];

  int            n_checks = 0;
  int            n_pass   = 0;
  bit            mon_en   = 1'b0;
  logic [31:0]   exp_pc   = '0;
  logic [31:0]   exp_req  = '0;
  int            outst    = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 512; i++) sram_mem[i] = 32'h1000_0000 + 32'(i);
  end

  // Synchronous-read SRAM: sampled at the edge, data valid before the next edge.
  always @(posedge clk) begin
    if (sram_csb === 1'b0) sram_dout <= sram_mem[sram_addr];
  end

  imem_fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .fetch_fault   (fetch_fault),
    .sram_csb      (sram_csb),
    .sram_addr     (sram_addr),
    .sram_dout     (sram_dout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef IMEM_MISALIGN_FAULT_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return 32'h1000_0000 + {23'd0, p[10:2]};
  endfunction

  task automatic model_clear();
    exp_pc  = 32'h0000_0000;
    exp_req = 32'h0000_0000;
    outst   = 0;
  endtask

  // Stream model: every presented instruction continues the program-order
  // sequence, requests are contiguous, and outstanding work never exceeds FD.
  task automatic mon();
    if (!mon_en) return;
    if (inst_valid) begin
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_data", inst_data, word_at(inst_pc));
      if (inst_ready && !redirect_valid) begin
        exp_pc = exp_pc + 32'd4;
        outst--;
      end
    end
    if (redirect_valid) begin
      exp_pc  = tgt_of(redirect_pc);
      exp_req = tgt_of(redirect_pc);
      outst   = 0;
`ifdef IMEM_MISALIGN_FAULT_EN
      if (redirect_pc[1:0] != 2'b00) chk("fault_noreq", 32'(sram_csb), 32'd1);
`endif
    end
    if (sram_csb === 1'b0) begin
      chk("req_addr", 32'(sram_addr), {23'd0, exp_req[10:2]});
      exp_req = exp_req + 32'd4;
      outst++;
    end
    chk("credit", (outst >= 0 && outst <= int'(FD)) ? 32'd1 : 32'd0, 32'd1);
`ifndef IMEM_MISALIGN_FAULT_EN
    chk("fault_tied", 32'(fetch_fault), 32'd0);
`endif
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
    mon();
  endtask

  task automatic reset_checks();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_csb", 32'(sram_csb), 32'd1);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
  endtask

  task automatic release_rst(input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = 1'b1;
    model_clear();
    mon_en = 1'b1;
    #1;
    chk("boot_csb", 32'(sram_csb), 32'd1);
    mon();
  endtask

  logic        tv [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] tp [14] = '{32'h0, 32'h0, 32'h0, 32'h0C3, 32'h0, 32'h0, 32'h0,
                           32'h0, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        tr [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                           1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #2 rst = 1'b1;
    @(negedge clk); #1;
    reset_checks();

    // Boot and steady streaming
    release_rst(1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("first_csb", 32'(sram_csb), 32'd0);
    chk("first_addr", 32'(sram_addr), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("latency_valid", 32'(inst_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_data", inst_data, 32'h1000_0000);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 32'h0, 1'b1);
      chk("stream_gap", 32'(inst_valid), 32'd1);
    end
    chk("steady_pc", inst_pc, 32'h18);

    // Decode stall: FIFO fills, requests stop
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h0, 1'b0);
      chk("stall_csb", 32'(sram_csb), 32'd1);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_pc", inst_pc, 32'h1C);
    end
    cyc(1'b0, 32'h0, 1'b1);
    chk("resume_pc", inst_pc, 32'h1C);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("resume_pc2", inst_pc, 32'h24);

    // Redirect with a full pipeline
    cyc(1'b1, 32'h100, 1'b0);
    chk("redir_csb", 32'(sram_csb), 32'd0);
    chk("redir_addr", 32'(sram_addr), 32'd64);
    cyc(1'b0, 32'h0, 1'b1);
    chk("redir_flush", 32'(inst_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("redir_valid", 32'(inst_valid), 32'd1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_data", inst_data, 32'h1000_0040);

    // SRAM address wrap
    cyc(1'b1, 32'h7FC, 1'b1);
    chk("wrap_addr_hi", 32'(sram_addr), 32'd511);
    cyc(1'b0, 32'h0, 1'b1);
    chk("wrap_csb", 32'(sram_csb), 32'd0);
    chk("wrap_addr_lo", 32'(sram_addr), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("wrap_pc_hi", inst_pc, 32'h7FC);
    chk("wrap_data_hi", inst_data, 32'h1000_01FF);
    cyc(1'b0, 32'h0, 1'b1);
    chk("wrap_pc_lo", inst_pc, 32'h800);
    chk("wrap_data_lo", inst_data, 32'h1000_0000);

    // Asynchronous reset mid-stream, then redirect during boot
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    release_rst(1'b1, 32'h40);
    cyc(1'b0, 32'h0, 1'b1);
    chk("bootredir_csb", 32'(sram_csb), 32'd0);
    chk("bootredir_addr", 32'(sram_addr), 32'd16);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("bootredir_pc", inst_pc, 32'h40);
    chk("bootredir_data", inst_data, 32'h1000_0010);

    // Mixed ready/redirect traffic checked by the stream model
    for (int i = 0; i < 14; i++) cyc(tv[i], tp[i], tr[i]);

`ifdef IMEM_MISALIGN_FAULT_EN
    cyc(1'b1, 32'h102, 1'b1);
    chk("fault_csb0", 32'(sram_csb), 32'd1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_valid", 32'(inst_valid), 32'd0);
    chk("fault_pc", inst_pc, 32'h102);
    chk("fault_csb1", 32'(sram_csb), 32'd1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("fault_csb2", 32'(sram_csb), 32'd1);
    cyc(1'b1, 32'h200, 1'b1);
    chk("unfault_addr", 32'(sram_addr), 32'd128);
    cyc(1'b0, 32'h0, 1'b1);
    chk("unfault_clr", 32'(fetch_fault), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("unfault_pc", inst_pc, 32'h200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
